ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable.
- It is the reverse direction of the keyboard receiver and shares the same PS2_CLK/PS2_DAT open-drain pair.
- Sits beside the keyboard receiver in rtl_top. The top maps each *_oe output to a tri-state driver that drives 0 when oe=1 and Z otherwise.
- The receiver gates itself off while busy=1.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 10;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus a falling-edge detector on the
// synchronised level; shared with the keyboard receiver.
module ps2_sync_edge (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            meta_p0 <= raw;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX     = 4'(PS2_FRAME_BITS - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    ps2_state_t                state;
    logic [CNT_W-1:0]          cnt;
    logic [3:0]                idx;
    logic [PS2_FRAME_BITS-1:0] frame;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic unused_dat_fall;

    logic accept;

    ps2_sync_edge u_clk_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .raw     (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .raw     (ps2_dat_in),
        .level   (dat_level),
        .fall    (unused_dat_fall)
    );

    assign accept = (state == IDLE) && tx_ready && tx_valid;
    assign busy   = ~tx_ready;

    // Frame is pure data: captured on acceptance, so tx_data may change afterwards.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            frame <= {1'b1, odd_parity(tx_data), tx_data};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            tx_ready   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    // tx_ready is low during the done/error cycle, so nothing
                    // is accepted until the cycle after the pulse.
                    if (accept) begin
                        tx_ready   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        cnt        <= '0;
                        state      <= INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b1;
                        idx        <= '0;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~frame[idx];
                        idx        <= idx + 4'd1;
                        cnt        <= '0;
                        if (idx == LAST_IDX) begin
                            state <= ACK;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        error      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        cnt <= '0;
                        if (!dat_level) begin
                            state <= WAIT_IDLE;
                        end else begin
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b0;
                            error      <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        error      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && dat_level) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (clk_fall) begin
                        cnt <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        error      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model that
// clocks at a 40-cycle period and records the bits it samples.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 50;
    localparam int TMO = 2000;
    localparam int NV  = 5;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk, dev_dat;
    logic       bus_clk, bus_dat;

    assign bus_clk = dev_clk & ~ps2_clk_oe;
    assign bus_dat = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (bus_clk),
        .ps2_dat_in (bus_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int oe_viol = 0;
    int ready_viol = 0;
    logic prev_pulse = 1'b0;

    // Pulse monitor: pulses never overlap, lines are released during a pulse,
    // tx_ready is low during the pulse and high the cycle after.
    always @(negedge sys_clk) begin
        prev_pulse <= done | error;
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
        if ((done || error) && (ps2_clk_oe || ps2_dat_oe)) oe_viol <= oe_viol + 1;
        if ((done || error) && tx_ready) ready_viol <= ready_viol + 1;
        if (prev_pulse && rst_n && !tx_ready) ready_viol <= ready_viol + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       busy_req;
        logic [9:0] exp_frame;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after inhibit.
    task automatic start_tx(input string tag, input logic [7:0] d, input logic [7:0] after,
                            input logic keep_valid);
        int n;
        check({tag, "_ready"}, {31'd0, tx_ready}, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge sys_clk);
        #1;
        tx_valid = keep_valid;
        tx_data  = after;
        n = 0;
        @(negedge sys_clk);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge sys_clk);
        end
        check({tag, "_inhibit_len"}, n, INH);
        check({tag, "_rts"}, {31'd0, ps2_dat_oe}, 1);
    endtask

    task automatic dev_frame(input logic ack, input int nfalls, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10 && ack) dev_dat = 1'b0;
            repeat (20) @(negedge sys_clk);
            dev_clk = 1'b0;
            if (i == nfalls - 1 && nfalls < 11) return;
            repeat (20) @(negedge sys_clk);
            if (i < 10) bits[i] = bus_dat;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        int n, base_d, base_e;
        string tag;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;

        vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b0, 10'h3ED, 1, 0};
        vecs[1] = '{8'h01,            1'b1, 1'b0, 10'h201, 1, 0};
        vecs[2] = '{PS2_CMD_RESET,    1'b1, 1'b0, 10'h3FF, 1, 0};
        vecs[3] = '{8'h00,            1'b0, 1'b0, 10'h300, 0, 1};
        vecs[4] = '{PS2_CMD_ENABLE,   1'b1, 1'b1, 10'h2F4, 1, 0};

        repeat (3) @(negedge sys_clk);
        check("reset_state", {26'd0, tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int v = 0; v < NV; v++) begin
            tag = $sformatf("vec%0d", v);
            base_d = done_cnt;
            base_e = err_cnt;
            start_tx(tag, vecs[v].data, vecs[v].busy_req ? 8'h55 : ~vecs[v].data, vecs[v].busy_req);
            dev_frame(vecs[v].ack, 11, bits);
            check({tag, "_frame"}, {22'd0, bits}, {22'd0, vecs[v].exp_frame});
            n = 0;
            while (done_cnt + err_cnt == base_d + base_e && n < 200) begin
                @(negedge sys_clk);
                n++;
            end
            tx_valid = 1'b0;
            check({tag, "_done_pulses"}, done_cnt - base_d, vecs[v].exp_done);
            check({tag, "_error_pulses"}, err_cnt - base_e, vecs[v].exp_err);
            repeat (5) @(negedge sys_clk);
            check({tag, "_idle_after"}, {29'd0, tx_ready, ps2_clk_oe, ps2_dat_oe}, 3'b100);
        end

        // Silent device: nothing clocks after the request.
        base_d = done_cnt;
        start_tx("silent", PS2_CMD_ENABLE, 8'h00, 1'b0);
        n = 0;
        while (!error && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check("silent_timeout_cycles", n, TMO);
        check("silent_oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b00);
        @(negedge sys_clk);
        check("silent_ready_after", {31'd0, tx_ready}, 1);
        check("silent_no_done", done_cnt - base_d, 0);

        // Reset after the device's 5th falling edge.
        start_tx("rstmid", PS2_CMD_SET_LEDS, 8'h00, 1'b0);
        dev_frame(1'b1, 5, bits);
        repeat (5) @(negedge sys_clk);
        check("rstmid_driving_bit4", {31'd0, ps2_dat_oe}, 1);
        base_d = done_cnt;
        base_e = err_cnt;
        rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("rstmid_released", {28'd0, tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
        dev_clk = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("rstmid_no_pulses", (done_cnt - base_d) + (err_cnt - base_e), 0);
        check("rstmid_idle", {29'd0, tx_ready, ps2_clk_oe, ps2_dat_oe}, 3'b100);

        check("pulse_overlap", both_cnt, 0);
        check("pulse_oe_released", oe_viol, 0);
        check("pulse_ready_timing", ready_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
